// File: rtl/seq_divider_32b_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider_32b_pkg
// Brief   : Shared ALU divider definitions (width, FSM encodings, /0 result).
// Rev     : 1.0  initial release
// ============================================================================
package seq_divider_32b_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [31:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/seq_divider_32b_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step_32b
// Brief   : One combinational restoring-division step (shift, trial subtract).
// Rev     : 1.0  initial release
// ============================================================================
module div_step_32b
  import seq_divider_32b_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quo_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_in < divisor, so the shifted value fits WIDTH+1 bits and the trial
  // MSB is a clean borrow indicator.
  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {1'b0, divisor};
    quo_bit = ~trial[WIDTH];
    rem_out = quo_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/seq_divider_32b.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider_32b
// Brief   : Sequential 32-bit restoring divider, one quotient bit per clock.
//           Optional signed mode: define SEQ_DIVIDER_SIGNED_EN.
// Rev     : 1.0  initial release
// ============================================================================
module seq_divider_32b
  import seq_divider_32b_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] mag_dividend;
  logic [WIDTH-1:0] mag_divisor;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;

  assign accept    = (state_q == ST_IDLE) && start;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign step_quo  = {quo_q[WIDTH-2:0], step_bit};

  // quo_q starts as the dividend; its MSB feeds the step while quotient
  // bits shift in from the bottom.
  div_step_32b #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_bit (step_bit)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  always_comb begin
    mag_dividend = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_divisor  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    if (accept) begin
      neg_quo_d = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem_d = signed_op && dividend[WIDTH-1];
    end
    fix_quo = neg_quo_q ? -step_quo : step_quo;
    fix_rem = neg_rem_q ? -step_rem : step_rem;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  always_comb begin
    mag_dividend = dividend;
    mag_divisor  = divisor;
    fix_quo      = step_quo;
    fix_rem      = step_rem;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (divisor == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Datapath next values; result registers move only when entering DONE.
  always_comb begin
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (accept) begin
      rem_d = '0;
      quo_d = mag_dividend;
      dvs_d = mag_divisor;
      cnt_d = '0;
      dbz_d = 1'b0;
      if (divisor == '0) begin
        quotient_d  = DZ_QUOTIENT;
        remainder_d = dividend;
        dbz_d       = 1'b1;
      end
    end else if (state_q == ST_CALC) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_step) begin
        quotient_d  = fix_quo;
        remainder_d = fix_rem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
